// File: rtl/hash160_pkg.sv
// Shared constants and state type for the Hash160 front end: start-byte default,
// block geometry and the fixed SHA-256 padding words for a 512-bit message.
package hash160_pkg;

   localparam logic [7:0]  DEFAULT_START_BYTE = 8'hAA;
   localparam int          WORDS_PER_BLOCK    = 16;
   localparam int          MSG_BYTES          = 64;
   localparam logic [31:0] PAD_WORD0          = 32'h8000_0000;
   localparam logic [31:0] LEN_WORD           = 32'h0000_0200;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_SEND1,
      ST_SEND2
   } loader_state_t;

endpackage

// File: rtl/hash160_msg_loader.sv
// Captures a 64-byte message after START_BYTE and streams it as a message block plus
// a fixed padding block of 16 big-endian words each. Optional macro: LOADER_STATUS_EN.
module hash160_msg_loader
   import hash160_pkg::*;
#(
   parameter logic [7:0] START_BYTE = DEFAULT_START_BYTE
`ifdef LOADER_STATUS_EN
   ,parameter int CNT_W = 8
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  i_text,
   output logic [31:0] o_word,
   output logic        o_word_valid,
   input  logic        i_word_ready,
   output logic [3:0]  o_word_idx,
   output logic        o_block_first,
   output logic        o_block_last,
   output logic        o_busy
`ifdef LOADER_STATUS_EN
   ,output logic [CNT_W-1:0] o_msg_count
`endif
);

   loader_state_t state_reg, state_next;
   logic [5:0]    byte_cnt_reg, byte_cnt_next;
   logic [3:0]    idx_reg, idx_next;
   logic [7:0]    byte_mem [MSG_BYTES];
   logic [31:0]   buf_word [WORDS_PER_BLOCK];
   logic [31:0]   pad_word;
   logic          last_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         byte_cnt_reg <= '0;
         idx_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         byte_cnt_reg <= byte_cnt_next;
         idx_reg      <= idx_next;
      end
   end

   // Message storage holds don't-care data outside a capture, so it needs no reset.
   always_ff @(posedge clk) begin
      if (state_reg == ST_COLLECT)
         byte_mem[byte_cnt_reg] <= i_text;
   end

   for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_pack
      assign buf_word[gi] = {byte_mem[4*gi], byte_mem[4*gi+1],
                             byte_mem[4*gi+2], byte_mem[4*gi+3]};
   end

   assign last_word = (idx_reg == 4'(WORDS_PER_BLOCK - 1));

   always_comb begin
      pad_word = '0;
      if (idx_reg == 4'd0)
         pad_word = PAD_WORD0;
      else if (last_word)
         pad_word = LEN_WORD;
   end

   always_comb begin
      state_next    = state_reg;
      byte_cnt_next = byte_cnt_reg;
      idx_next      = idx_reg;
      o_word        = '0;
      o_word_valid  = 1'b0;
      o_block_first = 1'b0;
      o_block_last  = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            byte_cnt_next = '0;
            if (i_text == START_BYTE)
               state_next = ST_COLLECT;
         end
         ST_COLLECT: begin
            byte_cnt_next = byte_cnt_reg + 6'd1;
            if (byte_cnt_reg == 6'(MSG_BYTES - 1))
               state_next = ST_SEND1;
         end
         ST_SEND1: begin
            o_word        = buf_word[idx_reg];
            o_word_valid  = 1'b1;
            o_block_first = 1'b1;
            if (i_word_ready) begin
               idx_next = idx_reg + 4'd1;
               if (last_word)
                  state_next = ST_SEND2;
            end
         end
         ST_SEND2: begin
            o_word       = pad_word;
            o_word_valid = 1'b1;
            o_block_last = 1'b1;
            if (i_word_ready) begin
               idx_next = idx_reg + 4'd1;
               if (last_word)
                  state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign o_word_idx = idx_reg;
   assign o_busy     = (state_reg != ST_IDLE);

`ifdef LOADER_STATUS_EN
   logic [CNT_W-1:0] msg_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         msg_count_reg <= '0;
      else if (state_reg == ST_SEND2 && i_word_ready && last_word)
         msg_count_reg <= msg_count_reg + 1'b1;
   end

   assign o_msg_count = msg_count_reg;
`endif

endmodule

// File: tb/tb_hash160_msg_loader.sv
// Directed bench for hash160_msg_loader: table of expected words per message,
// plus hand-written reset, backpressure and start-during-send sequences.
module tb_hash160_msg_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  i_text = 8'h00;
   logic [31:0] o_word;
   logic        o_word_valid;
   logic        i_word_ready = 1'b0;
   logic [3:0]  o_word_idx;
   logic        o_block_first;
   logic        o_block_last;
   logic        o_busy;
`ifdef LOADER_STATUS_EN
   logic [7:0]  o_msg_count;
`endif

   hash160_msg_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_text       (i_text),
      .o_word       (o_word),
      .o_word_valid (o_word_valid),
      .i_word_ready (i_word_ready),
      .o_word_idx   (o_word_idx),
      .o_block_first(o_block_first),
      .o_block_last (o_block_last),
      .o_busy       (o_busy)
`ifdef LOADER_STATUS_EN
      ,.o_msg_count (o_msg_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  idx;
      logic        first;
      logic        last;
      logic [31:0] word;
   } vec_t;

   vec_t        exp_tbl [32];
   logic [7:0]  msg [64];
   logic [15:0] lfsr = 16'hACE1;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total_cnt++;
      if (act === req)
         pass_cnt++;
      else
         $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_byte(input logic [7:0] b);
      i_text = b;
      cyc();
   endtask

   // Block 1 is the message packed big-endian; block 2 is the fixed pad for 512 bits.
   task automatic fill_expected();
      for (int i = 0; i < 16; i++) begin
         exp_tbl[i].idx   = 4'(i);
         exp_tbl[i].first = 1'b1;
         exp_tbl[i].last  = 1'b0;
         exp_tbl[i].word  = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
         exp_tbl[16+i].idx   = 4'(i);
         exp_tbl[16+i].first = 1'b0;
         exp_tbl[16+i].last  = 1'b1;
         exp_tbl[16+i].word  = (i == 0) ? 32'h8000_0000 :
                               (i == 15) ? 32'h0000_0200 : 32'h0;
      end
   endtask

   task automatic send_msg();
      logic saw_valid;
      saw_valid = 1'b0;
      drive_byte(8'hAA);
      chk("armed_busy_valid", {62'd0, o_busy, o_word_valid}, {62'd0, 1'b1, 1'b0});
      for (int k = 0; k < 64; k++) begin
         if (o_word_valid) saw_valid = 1'b1;
         drive_byte(msg[k]);
      end
      chk("no_valid_in_collect", {63'd0, saw_valid}, 64'd0);
      chk("first_valid_latency", {63'd0, o_word_valid}, 64'd1);
   endtask

   // mode 0: ready held high; mode 1: ready from LFSR. txt is driven on i_text throughout.
   task automatic run_words(input int mode, input logic [7:0] txt);
      int          n, cycles;
      logic        r, hold_pending;
      logic [31:0] hw;
      logic [3:0]  hi;
      n = 0; cycles = 0; hold_pending = 1'b0; hw = '0; hi = '0;
      while (n < 32 && cycles < 400) begin
         if (hold_pending)
            chk("hold_word_idx", {28'd0, o_word_idx, o_word}, {28'd0, hi, hw});
         if (mode == 0) begin
            r = 1'b1;
            chk("valid_consecutive", {63'd0, o_word_valid}, 64'd1);
         end else begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            r = lfsr[0];
         end
         i_word_ready = r;
         i_text = txt;
         if (o_word_valid && r) begin
            $display("accept %0d: blk%0d idx=%0d word=%h", n, o_block_last ? 2 : 1, o_word_idx, o_word);
            chk($sformatf("word%0d", n),
                {26'd0, o_word_idx, o_block_first, o_block_last, o_word},
                {26'd0, exp_tbl[n].idx, exp_tbl[n].first, exp_tbl[n].last, exp_tbl[n].word});
            n++;
         end
         hold_pending = o_word_valid && !r;
         hw = o_word;
         hi = o_word_idx;
         cyc();
         cycles++;
      end
      i_word_ready = 1'b0;
      chk("accept_count", 64'(n), 64'd32);
      if (mode == 0)
         chk("send_cycles", 64'(cycles), 64'd32);
      chk("idle_after_send", {62'd0, o_busy, o_word_valid}, 64'd0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      chk("reset_outputs",
          {26'd0, o_busy, o_word_valid, o_block_first, o_block_last, o_word_idx, o_word}, 64'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      logic any_act;

      // Reset state
      i_text = 8'h00;
      cyc();
      chk("reset_state",
          {26'd0, o_busy, o_word_valid, o_block_first, o_block_last, o_word_idx, o_word}, 64'd0);
      rst_n = 1'b1;
      cyc();
      chk("idle_after_reset", {62'd0, o_busy, o_word_valid}, 64'd0);

      // Basic message, ready high
      for (int k = 0; k < 64; k++) msg[k] = 8'(k);
      fill_expected();
      chk("tbl_word0", {32'd0, exp_tbl[0].word}, 64'h0001_0203);
      chk("tbl_word15", {32'd0, exp_tbl[15].word}, 64'h3C3D_3E3F);
      send_msg();
      run_words(0, 8'h00);

      // Backpressure
      send_msg();
      run_words(1, 8'h00);

      // Idle filtering then all-0xAA message
      drive_byte(8'h00);
      chk("idle_0x00", {62'd0, o_busy, o_word_valid}, 64'd0);
      drive_byte(8'h55);
      chk("idle_0x55", {62'd0, o_busy, o_word_valid}, 64'd0);
      drive_byte(8'hAB);
      chk("idle_0xAB", {62'd0, o_busy, o_word_valid}, 64'd0);
      for (int k = 0; k < 64; k++) msg[k] = 8'hAA;
      fill_expected();
      send_msg();
      run_words(0, 8'h00);

      // Reset mid-collect
      drive_byte(8'hAA);
      for (int k = 0; k < 20; k++) drive_byte(8'(k + 1));
      pulse_reset();
      any_act = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (o_busy || o_word_valid) any_act = 1'b1;
         drive_byte(8'h11);
      end
      chk("no_output_after_reset", {63'd0, any_act}, 64'd0);
      for (int k = 0; k < 64; k++) msg[k] = 8'(8'hC0 ^ 8'(3 * k));
      fill_expected();
      send_msg();
      run_words(0, 8'h00);

      // Start byte during send is ignored, including on the final accept
      for (int k = 0; k < 64; k++) msg[k] = 8'(255 - k);
      fill_expected();
      send_msg();
      run_words(1, 8'hAA);
      drive_byte(8'h00);
      chk("still_idle", {62'd0, o_busy, o_word_valid}, 64'd0);
      send_msg();
      run_words(0, 8'h00);

`ifdef LOADER_STATUS_EN
      pulse_reset();
      chk("count_after_reset", {56'd0, o_msg_count}, 64'd0);
      for (int m = 1; m <= 3; m++) begin
         for (int k = 0; k < 64; k++) msg[k] = 8'(m * 17 + k);
         fill_expected();
         send_msg();
         run_words(0, 8'h00);
         chk($sformatf("msg_count_%0d", m), {56'd0, o_msg_count}, 64'(m));
      end
      pulse_reset();
      chk("count_cleared", {56'd0, o_msg_count}, 64'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
